// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Multi-cycle data-memory access engine. Runs one valid/ready bus
//            transaction per load/store and stalls the core until it commits.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  func3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        misaligned,
    output logic        bus_error,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic        bus_req_we,
    output logic [31:0] bus_req_addr,
    output logic [31:0] bus_req_wdata,
    output logic [3:0]  bus_req_strb,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rsp_rdata,
    input  logic        bus_rsp_err
);

    localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_rsp  = 2'd2;
    localparam logic [1:0] c_st_done = 2'd3;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [31:0]        r_addr;
    logic [2:0]         r_func3;
    logic               r_we;
    logic               r_err;
    logic [31:0]        r_wdata;
    logic [3:0]         r_strb;
    logic [31:0]        r_load_data;

    logic        w_idle;
    logic        w_access;
    logic        w_legal;
    logic        w_aligned;
    logic        w_launch;
    logic        w_timeout;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_idle   = (r_state == c_st_idle);
    assign w_access = mem_read | mem_write;

    // Unsigned-load encodings are only meaningful for reads.
    always_comb begin
        w_legal = 1'b0;
        case (func3)
            3'b000, 3'b001, 3'b010: w_legal = 1'b1;
            3'b100, 3'b101:         w_legal = ~mem_write;
            default:                w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_aligned = 1'b1;
        case (func3[1:0])
            2'b01:   w_aligned = ~addr[0];
            2'b10:   w_aligned = (addr[1:0] == 2'b00);
            default: w_aligned = 1'b1;
        endcase
    end

    assign w_launch  = w_idle & w_access & w_legal & w_aligned;
    assign w_timeout = (r_cnt >= c_cnt_last);

    always_comb begin
        w_strb  = 4'b1111;
        w_wdata = store_data;
        case (func3[1:0])
            2'b00: begin
                w_strb  = 4'b0001 << addr[1:0];
                w_wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                w_strb  = 4'b0011 << addr[1:0];
                w_wdata = {2{store_data[15:0]}};
            end
            default: begin
                w_strb  = 4'b1111;
                w_wdata = store_data;
            end
        endcase
        if (!mem_write) begin
            w_strb = 4'b0000;
        end
    end

    always_comb begin
        w_byte = bus_rsp_rdata[7:0];
        case (r_addr[1:0])
            2'd0: w_byte = bus_rsp_rdata[7:0];
            2'd1: w_byte = bus_rsp_rdata[15:8];
            2'd2: w_byte = bus_rsp_rdata[23:16];
            2'd3: w_byte = bus_rsp_rdata[31:24];
            default: w_byte = bus_rsp_rdata[7:0];
        endcase
        w_half = r_addr[1] ? bus_rsp_rdata[31:16] : bus_rsp_rdata[15:0];
        case (r_func3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'h000000, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'h0000, w_half};
            default: w_ext = bus_rsp_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_addr      <= 32'h0;
            r_func3     <= 3'b000;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_wdata     <= 32'h0;
            r_strb      <= 4'b0000;
            r_load_data <= 32'h0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_launch) begin
                        r_addr  <= addr;
                        r_func3 <= func3;
                        r_we    <= mem_write;
                        r_wdata <= w_wdata;
                        r_strb  <= w_strb;
                        r_err   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_st_req;
                    end
                end
                c_st_req: begin
                    r_cnt <= r_cnt + 1'b1;
                    // An accepted request always proceeds; the RSP check
                    // still enforces the overall cycle budget.
                    if (bus_req_ready) begin
                        r_state <= c_st_rsp;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                        if (!r_we) begin
                            r_load_data <= 32'h0;
                        end
                    end
                end
                c_st_rsp: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (bus_rsp_valid) begin
                        r_err   <= bus_rsp_err;
                        r_state <= c_st_done;
                        if (!r_we) begin
                            r_load_data <= bus_rsp_err ? 32'h0 : w_ext;
                        end
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_done;
                        if (!r_we) begin
                            r_load_data <= 32'h0;
                        end
                    end
                end
                c_st_done: r_state <= c_st_idle;
                default:   r_state <= c_st_idle;
            endcase
        end
    end

    assign stall         = w_launch | (r_state == c_st_req) | (r_state == c_st_rsp);
    assign misaligned    = w_idle & w_access & w_legal & ~w_aligned;
    assign bus_error     = (w_idle & w_access & ~w_legal) | ((r_state == c_st_done) & r_err);
    assign load_valid    = (r_state == c_st_done) & ~r_we & ~r_err;
    assign load_data     = r_load_data;
    assign bus_req_valid = (r_state == c_st_req);
    assign bus_req_we    = r_we;
    assign bus_req_addr  = {r_addr[31:2], 2'b00};
    assign bus_req_wdata = r_wdata;
    assign bus_req_strb  = r_strb;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Directed self-checking bench with a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    localparam int TMO = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write;
    logic [2:0]  func3;
    logic [31:0] addr, store_data;
    logic        stall, load_valid, misaligned, bus_error;
    logic [31:0] load_data;
    logic        bus_req_valid, bus_req_ready, bus_req_we;
    logic [31:0] bus_req_addr, bus_req_wdata;
    logic [3:0]  bus_req_strb;
    logic        bus_rsp_valid, bus_rsp_err;
    logic [31:0] bus_rsp_rdata;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .func3(func3),
        .addr(addr), .store_data(store_data),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misaligned(misaligned), .bus_error(bus_error),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_req_we(bus_req_we), .bus_req_addr(bus_req_addr),
        .bus_req_wdata(bus_req_wdata), .bus_req_strb(bus_req_strb),
        .bus_rsp_valid(bus_rsp_valid), .bus_rsp_rdata(bus_rsp_rdata),
        .bus_rsp_err(bus_rsp_err)
    );

    typedef struct packed {
        logic        lv;
        logic        be;
        logic        mis;
        logic [31:0] data;
    } result_t;

    result_t     exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ld_model = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * int'(a)));
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'h0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'h0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] model_strb(input logic wr, input logic [2:0] f3,
                                              input logic [1:0] a);
        if (!wr) return 4'b0000;
        case (f3[1:0])
            2'b00:   return 4'(1 << a);
            2'b01:   return 4'(3 << a);
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        case (f3[1:0])
            2'b00:   return {4{sd[7:0]}};
            2'b01:   return {2{sd[15:0]}};
            default: return sd;
        endcase
    endfunction

    // One complete access: pushes the expected outcome, plays the bus slave,
    // and pops/compares whenever the DUT signals a result.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd,
                          input int rdy_wait, input logic [31:0] rdata, input logic err,
                          output int n_stall, output int n_valid);
        logic    legal, aligned, fin;
        int      phase, waited;
        result_t r;
        legal   = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                  (!wr && ((f3 == 3'b100) || (f3 == 3'b101)));
        aligned = (f3[1:0] == 2'b01) ? !a[0] : (f3[1:0] == 2'b10) ? (a[1:0] == 2'b00) : 1'b1;
        if (!legal) begin
            exp_q.push_back('{1'b0, 1'b1, 1'b0, ld_model});
        end else if (!aligned) begin
            exp_q.push_back('{1'b0, 1'b0, 1'b1, ld_model});
        end else if (rdy_wait >= TMO || err) begin
            if (!wr) ld_model = 32'h0;
            exp_q.push_back('{1'b0, 1'b1, 1'b0, ld_model});
        end else if (!wr) begin
            ld_model = model_load(f3, a[1:0], rdata);
            exp_q.push_back('{1'b1, 1'b0, 1'b0, ld_model});
        end

        @(negedge clk);
        mem_read = rd; mem_write = wr; func3 = f3; addr = a; store_data = sd;
        n_stall = 0; n_valid = 0; phase = 0; waited = 0; fin = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (stall) n_stall++;
            if (load_valid || bus_error || misaligned) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", 64'({load_valid, bus_error, misaligned}), 64'(0));
                end else begin
                    r = exp_q.pop_front();
                    chk("result", {29'b0, load_valid, bus_error, misaligned, load_data},
                        {29'b0, r});
                end
            end
            if (bus_req_valid) begin
                n_valid++;
                chk("req_addr", 64'(bus_req_addr), 64'({a[31:2], 2'b00}));
                chk("req_we", 64'(bus_req_we), 64'(wr));
                chk("req_strb", 64'(bus_req_strb), 64'(model_strb(wr, f3, a[1:0])));
                if (wr) chk("req_wdata", 64'(bus_req_wdata), 64'(model_wdata(f3, sd)));
            end
            case (phase)
                0: if (bus_req_valid) begin
                       if (waited == rdy_wait) begin
                           bus_req_ready = 1'b1;
                           phase = 1;
                       end else begin
                           waited++;
                       end
                   end
                1: begin
                       bus_req_ready = 1'b0;
                       bus_rsp_valid = 1'b1;
                       bus_rsp_rdata = rdata;
                       bus_rsp_err   = err;
                       phase = 2;
                   end
                default: begin
                       bus_rsp_valid = 1'b0;
                       bus_rsp_err   = 1'b0;
                   end
            endcase
            if (!stall) begin
                fin = 1'b1;
                mem_read = 1'b0; mem_write = 1'b0;
                bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_err = 1'b0;
            end
        end
        chk("access_done", 64'(fin), 64'(1));
        chk("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, nv;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; func3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_req_valid", 64'(bus_req_valid), 64'(0));
        chk("rst_load_valid", 64'(load_valid), 64'(0));
        chk("rst_load_data", 64'(load_data), 64'(0));
        chk("rst_req_addr", 64'(bus_req_addr), 64'(0));
        chk("rst_req_strb", 64'(bus_req_strb), 64'(0));
        chk("rst_bus_error", 64'(bus_error), 64'(0));

        // LW, immediate ready, one-cycle response
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, 1'b0, ns, nv);
        chk("lw_stall_cycles", 64'(ns), 64'(3));
        chk("lw_valid_cycles", 64'(nv), 64'(1));
        chk("lw_data", 64'(load_data), 64'(32'hDEADBEEF));

        access(1'b1, 1'b0, 3'b000, 32'h203, 32'h0, 0, 32'h80FFFF7F, 1'b0, ns, nv);
        chk("lb_data", 64'(load_data), 64'(32'hFFFFFF80));
        access(1'b1, 1'b0, 3'b100, 32'h203, 32'h0, 0, 32'h80FFFF7F, 1'b0, ns, nv);
        chk("lbu_data", 64'(load_data), 64'(32'h00000080));

        // SH with four ready-low cycles; request must hold steady
        access(1'b0, 1'b1, 3'b001, 32'h102, 32'h1234ABCD, 4, 32'h0, 1'b0, ns, nv);
        chk("sh_valid_cycles", 64'(nv), 64'(5));
        chk("sh_stall_cycles", 64'(ns), 64'(7));
        chk("sh_strb", 64'(bus_req_strb), 64'(4'b1100));
        chk("sh_wdata", 64'(bus_req_wdata), 64'(32'hABCDABCD));
        chk("sh_keeps_load_data", 64'(load_data), 64'(32'h00000080));

        access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'h0, 1'b0, ns, nv);
        chk("lw_mis_stall", 64'(ns), 64'(0));
        chk("lw_mis_valid", 64'(nv), 64'(0));
        access(1'b0, 1'b1, 3'b001, 32'h003, 32'h5555, 0, 32'h0, 1'b0, ns, nv);
        chk("sh_mis_stall", 64'(ns), 64'(0));
        chk("sh_mis_valid", 64'(nv), 64'(0));

        // Illegal encodings: load func3=011, store func3=100
        access(1'b1, 1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, 1'b0, ns, nv);
        chk("ill_ld_valid", 64'(nv), 64'(0));
        access(1'b0, 1'b1, 3'b100, 32'h100, 32'h0, 0, 32'h0, 1'b0, ns, nv);
        chk("ill_st_stall", 64'(ns), 64'(0));

        // LH with error response
        access(1'b1, 1'b0, 3'b001, 32'h002, 32'h0, 0, 32'h7FFF1234, 1'b1, ns, nv);
        chk("lh_err_data", 64'(load_data), 64'(0));

        access(1'b1, 1'b0, 3'b101, 32'h206, 32'h0, 1, 32'h80010000, 1'b0, ns, nv);
        chk("lhu_data", 64'(load_data), 64'(32'h00008001));
        access(1'b1, 1'b0, 3'b001, 32'h206, 32'h0, 0, 32'h80010000, 1'b0, ns, nv);
        chk("lh_data", 64'(load_data), 64'(32'hFFFF8001));
        access(1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 2, 32'h0, 1'b0, ns, nv);
        chk("sw_strb", 64'(bus_req_strb), 64'(4'b1111));
        access(1'b1, 1'b1, 3'b000, 32'h301, 32'h1234565A, 0, 32'h0, 1'b0, ns, nv);
        chk("sb_strb", 64'(bus_req_strb), 64'(4'b0010));
        chk("sb_wdata", 64'(bus_req_wdata), 64'(32'h5A5A5A5A));
        chk("sb_we", 64'(bus_req_we), 64'(1));

        // Reset during RSP abandons the access; a late response is ignored
        @(negedge clk);
        mem_read = 1'b1; func3 = 3'b010; addr = 32'h500;
        @(negedge clk); #1;
        chk("rr_req_valid", 64'(bus_req_valid), 64'(1));
        bus_req_ready = 1'b1;
        @(negedge clk); #1;
        bus_req_ready = 1'b0;
        chk("rr_rsp_stall", 64'(stall), 64'(1));
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk); #1;
        rst = 1'b0;
        chk("rr_stall", 64'(stall), 64'(0));
        chk("rr_req_valid_low", 64'(bus_req_valid), 64'(0));
        chk("rr_load_data", 64'(load_data), 64'(0));
        ld_model = 32'h0;
        bus_rsp_valid = 1'b1; bus_rsp_rdata = 32'h11111111;
        @(negedge clk); #1;
        bus_rsp_valid = 1'b0;
        chk("rr_late_rsp", 64'({load_valid, bus_error, stall}), 64'(0));
        chk("rr_late_data", 64'(load_data), 64'(0));

        // Slave never accepts: abort after TMO request cycles
        access(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, NEVER, 32'h0, 1'b0, ns, nv);
        chk("tmo_valid_cycles", 64'(nv), 64'(TMO));
        chk("tmo_stall_cycles", 64'(ns), 64'(TMO + 1));
        @(negedge clk); #1;
        chk("tmo_back_idle", 64'({stall, bus_req_valid, bus_error}), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access engine directly downstream of the main decoder.
- Consumes the decoder's mem_read/mem_write, the instruction func3, the ALU address and the rs2 store data.
- Runs one valid/ready request/response transaction on the data bus and returns aligned, sign/zero-extended load data.
- Holds stall high so the single-cycle core freezes PC and register writeback until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in REQ+RSP before the access is aborted with bus_error. Must be at least 2.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- mem_read  in  1  load request from decoder
- mem_write  in  1  store request from decoder
- func3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr  in  32  byte address from ALU
- store_data  in  32  rs2 value
- stall  out  1  freeze core (PC, regfile write)
- load_data  out  32  extended load result, valid while load_valid=1
- load_valid  out  1  one-cycle completion pulse for loads
- misaligned  out  1  one-cycle pulse for a misaligned access; no bus traffic
- bus_error  out  1  one-cycle pulse: bus error response, timeout, or illegal func3
- bus_req_valid  out  1  request valid
- bus_req_ready  in  1  request accepted
- bus_req_we  out  1  1 = write
- bus_req_addr  out  32  word address, {addr[31:2],2'b00}
- bus_req_wdata  out  32  lane-replicated store data
- bus_req_strb  out  4  byte enables; 0000 for reads
- bus_rsp_valid  in  1  response valid; always accepted
- bus_rsp_rdata  in  32  read data word
- bus_rsp_err  in  1  error flag, qualified by bus_rsp_valid

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Reset: state IDLE; timeout counter and all latched address/data/size registers 0; every registered output 0. Reset mid-transaction abandons it: bus_req_valid is 0 the cycle after rst. A late bus_rsp_valid arriving in IDLE is ignored.
- FSM states: IDLE, REQ, RSP, DONE.
- IDLE, start condition: access = mem_read|mem_write.
  - If access is set with legal func3 and aligned address: latch addr, func3, store_data and we=mem_write, then go to REQ. stall=1 combinationally in that same cycle.
  - mem_read and mem_write both high: treated as a store.
- Alignment rules: H/HU require addr[0]=0; W requires addr[1:0]=00. Store func3 is legal only for 000/001/010.
- Misaligned access in IDLE: misaligned=1 combinationally for that cycle; stall=0; stays in IDLE; no request issued.
- Illegal func3 in IDLE: bus_error=1 combinationally for that cycle; stall=0; stays in IDLE; no request issued.
- REQ: bus_req_valid=1. Addr, we, wdata and strb are driven from latched registers and stay stable until bus_req_ready. When valid&ready, go to RSP. bus_rsp_valid in REQ is ignored.
- RSP: wait for bus_rsp_valid, which is accepted unconditionally. On rsp_valid, capture extended rdata (0 if rsp_err) and go to DONE. Stores also wait for the response as a write acknowledgement.
- Timeout: counter clears on IDLE→REQ and increments each cycle in REQ or RSP. When it reaches TIMEOUT_CYCLES, go to DONE with the error flagged and load_data=0. In REQ this also deasserts bus_req_valid.
- DONE:
  - stall=0.
  - load_valid=1 if the access was a load with no error.
  - bus_error=1 if rsp_err or timeout.
  - Unconditional return to IDLE; the still-asserted mem_read/mem_write is not relaunched that cycle.
- stall = (IDLE & start condition) | REQ | RSP.
- Minimum latency is 3 stall cycles, then the DONE commit cycle.
- Store strobes and data:
  - SB: strb=0001<<addr[1:0], wdata={4{store_data[7:0]}}.
  - SH: strb=0011<<addr[1:0], wdata={2{store_data[15:0]}}.
  - SW: strb=1111, wdata=store_data.
- Load extract: lane chosen by addr[1:0] (halfword by addr[1]). LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- load_data holds its value after DONE until the next completion or rst.

Test Plan:
- LW addr=0x100, bus ready immediately, rdata=0xDEADBEEF one cycle later → bus_req_addr=0x100, strb=0000, stall high 3 cycles, then load_valid=1 and load_data=0xDEADBEEF.
- LB addr=0x203, rdata=0x80FF_FF7F then LBU addr=0x203 with the same rdata → load_data=0xFFFFFF80 then 0x00000080.
- SH addr=0x102, store_data=0x1234ABCD → bus_req_we=1, strb=1100, wdata=0xABCDABCD; request held stable over 4 cycles of ready=0.
- LW addr=0x101 → misaligned pulse, stall=0, bus_req_valid never asserted; same result for SH addr=0x003.
- LH with bus_rsp_err=1 → bus_error pulse in DONE, load_valid=0, load_data=0.
- TIMEOUT_CYCLES=8 with ready never asserted → bus_error after 8 REQ cycles and return to IDLE. Separately, rst asserted in RSP → next cycle IDLE, stall=0, and a late rsp_valid is ignored.
